game_controller: RTL and testbench

//  Game-flow FSM for the board-game core: picks 1P (vs AI, 3 levels) or 2P mode, alternates turns, validates and commits moves,

---
 rtl/game_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 tb/tb_game_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// game_controller
// Game-flow sequencer for the board-game core. It selects one-player (against
// the AI engine, three levels) or two-player play, alternates turns, validates
// and commits moves, supports undo and surrender, and declares the result.
//
// Ports
//   i_clk, i_rst_n        clock; reset is synchronous and active-high
//   i_mode                0/1/2 = 1P easy/normal/hard, 3 = 2P (latched on start)
//   i_start               begin a new game (IDLE or OVER only)
//   i_surrender           side to move resigns (HUMAN or AI)
//   i_prestep             undo request (HUMAN only)
//   i_row/i_col           human move, qualified by i_player_done
//   i_ai_done/i_ai_row/i_ai_col   AI move result
//   i_chk_done/i_win      win-checker handshake
//   o_state, o_turn       FSM state and side to move (0 black, 1 white)
//   o_we/o_wr_row/o_wr_col/o_wr_val   board write port (val 0 = erase)
//   o_chk_req, o_ai_req   one-cycle request strobes
//   o_ai_level            latched AI difficulty
//   o_invalid             rejected human move
//   o_winner, o_move_cnt  result (0 none, 1 black, 2 white, 3 draw), stones on board
module game_controller #(
    parameter int BOARD_N = 15,
    parameter int HIST_D  = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_mode,
    input  logic       i_start,
    input  logic       i_surrender,
    input  logic       i_prestep,
    input  logic [3:0] i_row,
    input  logic [3:0] i_col,
    input  logic       i_player_done,
    input  logic       i_ai_done,
    input  logic [3:0] i_ai_row,
    input  logic [3:0] i_ai_col,
    input  logic       i_chk_done,
    input  logic       i_win,
    output logic [2:0] o_state,
    output logic       o_turn,
    output logic       o_we,
    output logic [3:0] o_wr_row,
    output logic [3:0] o_wr_col,
    output logic [1:0] o_wr_val,
    output logic       o_chk_req,
    output logic       o_ai_req,
    output logic [1:0] o_ai_level,
    output logic       o_invalid,
    output logic [1:0] o_winner,
    output logic [7:0] o_move_cnt
);

    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int IDX_W = $clog2(CELLS);
    localparam int HP_W  = (HIST_D > 1) ? $clog2(HIST_D) : 1;
    localparam int HC_W  = $clog2(HIST_D + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HUMAN = 3'd1,
        ST_PLACE = 3'd2,
        ST_JUDGE = 3'd3,
        ST_AI    = 3'd4,
        ST_UNDO  = 3'd5,
        ST_OVER  = 3'd6
    } state_t;

    // Linear occupancy-bitmap index of a board cell.
    function automatic logic [IDX_W-1:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
        cell_idx = IDX_W'(int'(r) * BOARD_N + int'(c));
    endfunction

    function automatic logic in_range(input logic [3:0] r, input logic [3:0] c);
        in_range = (int'(r) < BOARD_N) && (int'(c) < BOARD_N);
    endfunction

    // History pointer moves circularly so that an overflowing push silently
    // overwrites the oldest entry.
    function automatic logic [HP_W-1:0] wp_inc(input logic [HP_W-1:0] p);
        if (p == HP_W'(HIST_D - 1)) begin
            wp_inc = HP_W'(0);
        end else begin
            wp_inc = p + HP_W'(1);
        end
    endfunction

    function automatic logic [HP_W-1:0] wp_dec(input logic [HP_W-1:0] p);
        if (p == HP_W'(0)) begin
            wp_dec = HP_W'(HIST_D - 1);
        end else begin
            wp_dec = p - HP_W'(1);
        end
    endfunction

    state_t            state_r, state_n;
    logic              turn_r, turn_n;
    logic [1:0]        level_r, level_n;
    logic              two_p_r, two_p_n;
    logic [CELLS-1:0]  board_r, board_n;
    logic [7:0]        hist_mem_r [HIST_D];
    logic [7:0]        hist_mem_n [HIST_D];
    logic [HP_W-1:0]   wp_r, wp_n;
    logic [HC_W-1:0]   hcnt_r, hcnt_n;
    logic [7:0]        cnt_r, cnt_n;
    logic [1:0]        winner_r, winner_n;
    logic              undo_left_r, undo_left_n;
    logic              we_r, we_n;
    logic [3:0]        wr_row_r, wr_row_n;
    logic [3:0]        wr_col_r, wr_col_n;
    logic [1:0]        wr_val_r, wr_val_n;
    logic              chk_req_r, chk_req_n;
    logic              ai_req_r, ai_req_n;
    logic              invalid_r, invalid_n;

    logic              hum_ok_s;
    logic              ai_ok_s;
    logic [7:0]        top_s;
    logic [HC_W-1:0]   need_s;
    logic [1:0]        stone_s;
    logic              pop_s;

    // Move legality: coordinate on the board and the cell still empty.
    always_comb begin
        hum_ok_s = 1'b0;
        ai_ok_s  = 1'b0;
        if (in_range(i_row, i_col)) begin
            hum_ok_s = !board_r[cell_idx(i_row, i_col)];
        end else begin
            hum_ok_s = 1'b0;
        end
        if (in_range(i_ai_row, i_ai_col)) begin
            ai_ok_s = !board_r[cell_idx(i_ai_row, i_ai_col)];
        end else begin
            ai_ok_s = 1'b0;
        end
    end

    // Top of the history stack and the number of entries one undo consumes.
    always_comb begin
        top_s   = hist_mem_r[wp_dec(wp_r)];
        need_s  = two_p_r ? HC_W'(1) : HC_W'(2);
        stone_s = turn_r ? 2'd2 : 2'd1;
    end

    // Next-state and next-output logic for the whole controller.
    always_comb begin
        state_n     = state_r;
        turn_n      = turn_r;
        level_n     = level_r;
        two_p_n     = two_p_r;
        board_n     = board_r;
        hist_mem_n  = hist_mem_r;
        wp_n        = wp_r;
        hcnt_n      = hcnt_r;
        cnt_n       = cnt_r;
        winner_n    = winner_r;
        undo_left_n = undo_left_r;
        we_n        = 1'b0;
        wr_row_n    = wr_row_r;
        wr_col_n    = wr_col_r;
        wr_val_n    = wr_val_r;
        chk_req_n   = 1'b0;
        ai_req_n    = 1'b0;
        invalid_n   = 1'b0;
        pop_s       = 1'b0;

        case (state_r)
            ST_IDLE, ST_OVER: begin
                if (i_start) begin
                    level_n  = (i_mode == 2'd3) ? 2'd0 : i_mode;
                    two_p_n  = (i_mode == 2'd3);
                    board_n  = {CELLS{1'b0}};
                    wp_n     = HP_W'(0);
                    hcnt_n   = HC_W'(0);
                    cnt_n    = 8'd0;
                    winner_n = 2'd0;
                    turn_n   = 1'b0;
                    state_n  = ST_HUMAN;
                end else begin
                    state_n = state_r;
                end
            end

            ST_HUMAN: begin
                if (i_surrender) begin
                    winner_n = turn_r ? 2'd1 : 2'd2;
                    state_n  = ST_OVER;
                end else if (i_prestep) begin
                    if (hcnt_r >= need_s) begin
                        // First pop happens on entry; a second one (1P) follows in UNDO.
                        pop_s       = 1'b1;
                        undo_left_n = !two_p_r;
                        turn_n      = two_p_r ? ~turn_r : turn_r;
                        state_n     = ST_UNDO;
                    end else begin
                        state_n = ST_HUMAN;
                    end
                end else if (i_player_done) begin
                    if (hum_ok_s) begin
                        we_n      = 1'b1;
                        wr_row_n  = i_row;
                        wr_col_n  = i_col;
                        wr_val_n  = stone_s;
                        chk_req_n = 1'b1;
                        state_n   = ST_PLACE;
                    end else begin
                        invalid_n = 1'b1;
                    end
                end else begin
                    state_n = ST_HUMAN;
                end
            end

            ST_AI: begin
                if (i_surrender) begin
                    winner_n = turn_r ? 2'd1 : 2'd2;
                    state_n  = ST_OVER;
                end else if (i_ai_done) begin
                    if (ai_ok_s) begin
                        we_n      = 1'b1;
                        wr_row_n  = i_ai_row;
                        wr_col_n  = i_ai_col;
                        wr_val_n  = stone_s;
                        chk_req_n = 1'b1;
                        state_n   = ST_PLACE;
                    end else begin
                        ai_req_n = 1'b1;
                    end
                end else begin
                    state_n = ST_AI;
                end
            end

            ST_PLACE: begin
                // The write strobe is visible this cycle; bookkeeping commits at its end.
                board_n[cell_idx(wr_row_r, wr_col_r)] = 1'b1;
                hist_mem_n[wp_r] = {wr_row_r, wr_col_r};
                wp_n    = wp_inc(wp_r);
                hcnt_n  = (hcnt_r == HC_W'(HIST_D)) ? hcnt_r : hcnt_r + HC_W'(1);
                cnt_n   = cnt_r + 8'd1;
                state_n = ST_JUDGE;
            end

            ST_JUDGE: begin
                if (i_chk_done) begin
                    if (i_win) begin
                        winner_n = stone_s;
                        state_n  = ST_OVER;
                    end else if (cnt_r == 8'(CELLS)) begin
                        winner_n = 2'd3;
                        state_n  = ST_OVER;
                    end else begin
                        turn_n = ~turn_r;
                        if (!two_p_r && !turn_r) begin
                            ai_req_n = 1'b1;
                            state_n  = ST_AI;
                        end else begin
                            state_n = ST_HUMAN;
                        end
                    end
                end else begin
                    state_n = ST_JUDGE;
                end
            end

            ST_UNDO: begin
                if (undo_left_r) begin
                    pop_s       = 1'b1;
                    undo_left_n = 1'b0;
                end else begin
                    state_n = ST_HUMAN;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (pop_s) begin
            board_n[cell_idx(top_s[7:4], top_s[3:0])] = 1'b0;
            wp_n     = wp_dec(wp_r);
            hcnt_n   = hcnt_r - HC_W'(1);
            cnt_n    = cnt_r - 8'd1;
            we_n     = 1'b1;
            wr_row_n = top_s[7:4];
            wr_col_n = top_s[3:0];
            wr_val_n = 2'd0;
        end else begin
            pop_s = 1'b0;
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            state_r     <= ST_IDLE;
            turn_r      <= 1'b0;
            level_r     <= 2'd0;
            two_p_r     <= 1'b0;
            board_r     <= {CELLS{1'b0}};
            hist_mem_r  <= '{default: 8'd0};
            wp_r        <= HP_W'(0);
            hcnt_r      <= HC_W'(0);
            cnt_r       <= 8'd0;
            winner_r    <= 2'd0;
            undo_left_r <= 1'b0;
            we_r        <= 1'b0;
            wr_row_r    <= 4'd0;
            wr_col_r    <= 4'd0;
            wr_val_r    <= 2'd0;
            chk_req_r   <= 1'b0;
            ai_req_r    <= 1'b0;
            invalid_r   <= 1'b0;
        end else begin
            state_r     <= state_n;
            turn_r      <= turn_n;
            level_r     <= level_n;
            two_p_r     <= two_p_n;
            board_r     <= board_n;
            hist_mem_r  <= hist_mem_n;
            wp_r        <= wp_n;
            hcnt_r      <= hcnt_n;
            cnt_r       <= cnt_n;
            winner_r    <= winner_n;
            undo_left_r <= undo_left_n;
            we_r        <= we_n;
            wr_row_r    <= wr_row_n;
            wr_col_r    <= wr_col_n;
            wr_val_r    <= wr_val_n;
            chk_req_r   <= chk_req_n;
            ai_req_r    <= ai_req_n;
            invalid_r   <= invalid_n;
        end
    end

    assign o_state    = state_r;
    assign o_turn     = turn_r;
    assign o_we       = we_r;
    assign o_wr_row   = wr_row_r;
    assign o_wr_col   = wr_col_r;
    assign o_wr_val   = wr_val_r;
    assign o_chk_req  = chk_req_r;
    assign o_ai_req   = ai_req_r;
    assign o_ai_level = level_r;
    assign o_invalid  = invalid_r;
    assign o_winner   = winner_r;
    assign o_move_cnt = cnt_r;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: a vector table for the 2P flow and
// hand-written sequences for 1P AI handshakes, undo, surrender and history depth.
module tb_game_controller;

    localparam int OP_NOP    = 0;
    localparam int OP_RST    = 1;
    localparam int OP_START  = 2;
    localparam int OP_PD     = 3;
    localparam int OP_AID    = 4;
    localparam int OP_CD     = 5;
    localparam int OP_PRE    = 6;
    localparam int OP_PREPD  = 7;
    localparam int OP_SURPD  = 8;
    localparam int OP_SURAID = 9;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HUMAN = 3'd1;
    localparam logic [2:0] S_PLACE = 3'd2;
    localparam logic [2:0] S_JUDGE = 3'd3;
    localparam logic [2:0] S_AI    = 3'd4;
    localparam logic [2:0] S_UNDO  = 3'd5;
    localparam logic [2:0] S_OVER  = 3'd6;

    typedef struct {
        int         op;
        logic [1:0] mode;
        logic [3:0] r;
        logic [3:0] c;
        logic       w;
        logic [2:0] e_state;
        logic       e_turn;
        logic       e_we;
        logic [3:0] e_row;
        logic [3:0] e_col;
        logic [1:0] e_val;
        logic       e_chk;
        logic       e_aireq;
        logic       e_inv;
        logic [1:0] e_winner;
        logic [7:0] e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] mode = 2'd0;
    logic start = 1'b0, sur = 1'b0, pre = 1'b0, pd = 1'b0, aid = 1'b0, cd = 1'b0, win = 1'b0;
    logic [3:0] row = 4'd0, col = 4'd0, ai_row = 4'd0, ai_col = 4'd0;
    logic [2:0] o_state;
    logic o_turn, o_we, o_chk_req, o_ai_req, o_invalid;
    logic [3:0] o_wr_row, o_wr_col;
    logic [1:0] o_wr_val, o_ai_level, o_winner;
    logic [7:0] o_move_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tv [24];

    always #5 clk = ~clk;

    game_controller #(.BOARD_N(15), .HIST_D(16)) dut (
        .i_clk(clk), .i_rst_n(rst), .i_mode(mode), .i_start(start),
        .i_surrender(sur), .i_prestep(pre), .i_row(row), .i_col(col),
        .i_player_done(pd), .i_ai_done(aid), .i_ai_row(ai_row), .i_ai_col(ai_col),
        .i_chk_done(cd), .i_win(win), .o_state(o_state), .o_turn(o_turn),
        .o_we(o_we), .o_wr_row(o_wr_row), .o_wr_col(o_wr_col), .o_wr_val(o_wr_val),
        .o_chk_req(o_chk_req), .o_ai_req(o_ai_req), .o_ai_level(o_ai_level),
        .o_invalid(o_invalid), .o_winner(o_winner), .o_move_cnt(o_move_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the clock edge.
    task automatic step(input int op, input logic [1:0] m, input logic [3:0] r,
                        input logic [3:0] c, input logic w);
        rst    = (op == OP_RST);
        start  = (op == OP_START);
        sur    = (op == OP_SURPD) || (op == OP_SURAID);
        pre    = (op == OP_PRE) || (op == OP_PREPD);
        pd     = (op == OP_PD) || (op == OP_PREPD) || (op == OP_SURPD);
        aid    = (op == OP_AID) || (op == OP_SURAID);
        cd     = (op == OP_CD);
        mode   = m;
        row    = r;
        col    = c;
        ai_row = r;
        ai_col = c;
        win    = w;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        step(OP_NOP, mode, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic core(input string tag, input logic [2:0] st, input logic t, input logic [7:0] c);
        chk({tag, "_state"}, int'(o_state), int'(st));
        chk({tag, "_turn"}, int'(o_turn), int'(t));
        chk({tag, "_cnt"}, int'(o_move_cnt), int'(c));
    endtask

    task automatic wr(input string tag, input logic [3:0] r, input logic [3:0] c, input logic [1:0] v);
        chk({tag, "_we"}, int'(o_we), 1);
        chk({tag, "_row"}, int'(o_wr_row), int'(r));
        chk({tag, "_col"}, int'(o_wr_col), int'(c));
        chk({tag, "_val"}, int'(o_wr_val), int'(v));
    endtask

    initial begin
        //        op         mode  r     c     w     state    turn  we    row   col   val   chk   aireq inv   winner cnt
        tv[0]  = '{OP_RST,   2'd0, 4'd0, 4'd0, 1'b0, S_IDLE,  1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        tv[1]  = '{OP_RST,   2'd0, 4'd0, 4'd0, 1'b0, S_IDLE,  1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        tv[2]  = '{OP_START, 2'd3, 4'd0, 4'd0, 1'b0, S_HUMAN, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        tv[3]  = '{OP_PD,    2'd3, 4'd7, 4'd7, 1'b0, S_PLACE, 1'b0, 1'b1, 4'd7, 4'd7, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
        tv[4]  = '{OP_NOP,   2'd3, 4'd0, 4'd0, 1'b0, S_JUDGE, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1};
        tv[5]  = '{OP_CD,    2'd3, 4'd0, 4'd0, 1'b0, S_HUMAN, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1};
        tv[6]  = '{OP_PD,    2'd3, 4'd7, 4'd7, 1'b0, S_HUMAN, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd1};
        tv[7]  = '{OP_PD,    2'd3, 4'd7, 4'd8, 1'b0, S_PLACE, 1'b1, 1'b1, 4'd7, 4'd8, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1};
        tv[8]  = '{OP_NOP,   2'd3, 4'd0, 4'd0, 1'b0, S_JUDGE, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2};
        tv[9]  = '{OP_CD,    2'd3, 4'd0, 4'd0, 1'b0, S_HUMAN, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2};
        tv[10] = '{OP_PD,    2'd3, 4'd15, 4'd0, 1'b0, S_HUMAN, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd2};
        tv[11] = '{OP_PREPD, 2'd3, 4'd0, 4'd0, 1'b0, S_UNDO,  1'b1, 1'b1, 4'd7, 4'd8, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1};
        tv[12] = '{OP_NOP,   2'd3, 4'd0, 4'd0, 1'b0, S_HUMAN, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1};
        tv[13] = '{OP_START, 2'd0, 4'd0, 4'd0, 1'b0, S_HUMAN, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1};
        tv[14] = '{OP_PD,    2'd3, 4'd7, 4'd8, 1'b0, S_PLACE, 1'b1, 1'b1, 4'd7, 4'd8, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1};
        tv[15] = '{OP_NOP,   2'd3, 4'd0, 4'd0, 1'b0, S_JUDGE, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2};
        tv[16] = '{OP_CD,    2'd3, 4'd0, 4'd0, 1'b1, S_OVER,  1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd2, 8'd2};
        tv[17] = '{OP_PD,    2'd3, 4'd1, 4'd1, 1'b0, S_OVER,  1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd2, 8'd2};
        tv[18] = '{OP_START, 2'd3, 4'd0, 4'd0, 1'b0, S_HUMAN, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        tv[19] = '{OP_PD,    2'd3, 4'd0, 4'd0, 1'b0, S_PLACE, 1'b0, 1'b1, 4'd0, 4'd0, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
        tv[20] = '{OP_NOP,   2'd3, 4'd0, 4'd0, 1'b0, S_JUDGE, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1};
        tv[21] = '{OP_CD,    2'd3, 4'd0, 4'd0, 1'b0, S_HUMAN, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1};
        tv[22] = '{OP_SURPD, 2'd3, 4'd2, 4'd2, 1'b0, S_OVER,  1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd1};
        tv[23] = '{OP_PD,    2'd3, 4'd3, 4'd3, 1'b0, S_OVER,  1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd1};

        for (int i = 0; i < 24; i++) begin
            step(tv[i].op, tv[i].mode, tv[i].r, tv[i].c, tv[i].w);
            chk($sformatf("v%0d_state", i), int'(o_state), int'(tv[i].e_state));
            chk($sformatf("v%0d_turn", i), int'(o_turn), int'(tv[i].e_turn));
            chk($sformatf("v%0d_we", i), int'(o_we), int'(tv[i].e_we));
            chk($sformatf("v%0d_chk", i), int'(o_chk_req), int'(tv[i].e_chk));
            chk($sformatf("v%0d_aireq", i), int'(o_ai_req), int'(tv[i].e_aireq));
            chk($sformatf("v%0d_inv", i), int'(o_invalid), int'(tv[i].e_inv));
            chk($sformatf("v%0d_winner", i), int'(o_winner), int'(tv[i].e_winner));
            chk($sformatf("v%0d_cnt", i), int'(o_move_cnt), int'(tv[i].e_cnt));
            if (tv[i].e_we) begin
                chk($sformatf("v%0d_wrrow", i), int'(o_wr_row), int'(tv[i].e_row));
                chk($sformatf("v%0d_wrcol", i), int'(o_wr_col), int'(tv[i].e_col));
                chk($sformatf("v%0d_wrval", i), int'(o_wr_val), int'(tv[i].e_val));
            end
        end

        // 1P normal: AI handshake, retry on bad AI moves.
        step(OP_START, 2'd1, 4'd0, 4'd0, 1'b0);
        core("p1_start", S_HUMAN, 1'b0, 8'd0);
        chk("p1_level", int'(o_ai_level), 1);
        step(OP_PD, 2'd1, 4'd0, 4'd0, 1'b0);
        wr("p1_h0", 4'd0, 4'd0, 2'd1);
        nop();
        step(OP_CD, 2'd1, 4'd0, 4'd0, 1'b0);
        core("p1_ai", S_AI, 1'b1, 8'd1);
        chk("p1_aireq", int'(o_ai_req), 1);
        nop();
        chk("p1_aireq_off", int'(o_ai_req), 0);
        step(OP_AID, 2'd1, 4'd0, 4'd0, 1'b0);
        chk("p1_occ_state", int'(o_state), int'(S_AI));
        chk("p1_occ_reissue", int'(o_ai_req), 1);
        chk("p1_occ_we", int'(o_we), 0);
        step(OP_AID, 2'd1, 4'd15, 4'd3, 1'b0);
        chk("p1_oor_reissue", int'(o_ai_req), 1);
        step(OP_AID, 2'd1, 4'd1, 4'd1, 1'b0);
        chk("p1_ai_place", int'(o_state), int'(S_PLACE));
        wr("p1_ai_wr", 4'd1, 4'd1, 2'd2);
        nop();
        step(OP_CD, 2'd1, 4'd0, 4'd0, 1'b0);
        core("p1_back", S_HUMAN, 1'b0, 8'd2);
        step(OP_PD, 2'd1, 4'd2, 4'd2, 1'b0);
        nop();
        step(OP_CD, 2'd1, 4'd0, 4'd0, 1'b0);
        step(OP_AID, 2'd1, 4'd3, 4'd3, 1'b0);
        nop();
        step(OP_CD, 2'd1, 4'd0, 4'd0, 1'b0);
        core("p1_four", S_HUMAN, 1'b0, 8'd4);

        // 1P undo pops two moves, one erase per cycle.
        step(OP_PRE, 2'd1, 4'd0, 4'd0, 1'b0);
        chk("u1_state", int'(o_state), int'(S_UNDO));
        wr("u1_pop1", 4'd3, 4'd3, 2'd0);
        nop();
        chk("u1_state2", int'(o_state), int'(S_UNDO));
        wr("u1_pop2", 4'd2, 4'd2, 2'd0);
        nop();
        core("u1_done", S_HUMAN, 1'b0, 8'd2);
        chk("u1_we_off", int'(o_we), 0);
        step(OP_PRE, 2'd1, 4'd0, 4'd0, 1'b0);
        wr("u2_pop1", 4'd1, 4'd1, 2'd0);
        nop();
        wr("u2_pop2", 4'd0, 4'd0, 2'd0);
        nop();
        core("u2_done", S_HUMAN, 1'b0, 8'd0);
        step(OP_PRE, 2'd1, 4'd0, 4'd0, 1'b0);
        core("u3_empty", S_HUMAN, 1'b0, 8'd0);
        chk("u3_we", int'(o_we), 0);

        // Surrender while the AI is thinking; its result in the same cycle is dropped.
        step(OP_PD, 2'd1, 4'd4, 4'd4, 1'b0);
        nop();
        step(OP_CD, 2'd1, 4'd0, 4'd0, 1'b0);
        step(OP_SURAID, 2'd1, 4'd5, 4'd5, 1'b0);
        core("s_ai", S_OVER, 1'b1, 8'd1);
        chk("s_ai_winner", int'(o_winner), 1);
        chk("s_ai_we", int'(o_we), 0);

        // Black makes five.
        step(OP_START, 2'd2, 4'd0, 4'd0, 1'b0);
        core("w_start", S_HUMAN, 1'b0, 8'd0);
        chk("w_level", int'(o_ai_level), 2);
        chk("w_winner0", int'(o_winner), 0);
        step(OP_PD, 2'd2, 4'd7, 4'd7, 1'b0);
        nop();
        step(OP_CD, 2'd2, 4'd0, 4'd0, 1'b1);
        core("w_over", S_OVER, 1'b0, 8'd1);
        chk("w_winner", int'(o_winner), 1);

        // History depth: 17 moves, only the last 16 can be undone.
        step(OP_START, 2'd3, 4'd0, 4'd0, 1'b0);
        core("h_start", S_HUMAN, 1'b0, 8'd0);
        for (int i = 0; i < 17; i++) begin
            step(OP_PD, 2'd3, 4'(i % 8), 4'(i / 8), 1'b0);
            chk($sformatf("h_mv%0d_we", i), int'(o_we), 1);
            nop();
            step(OP_CD, 2'd3, 4'd0, 4'd0, 1'b0);
            chk($sformatf("h_mv%0d_cnt", i), int'(o_move_cnt), i + 1);
        end
        for (int k = 0; k < 16; k++) begin
            step(OP_PRE, 2'd3, 4'd0, 4'd0, 1'b0);
            if (k == 0) begin
                wr("h_first_pop", 4'd0, 4'd2, 2'd0);
            end
            nop();
            chk($sformatf("h_un%0d_cnt", k), int'(o_move_cnt), 16 - k);
        end
        core("h_after", S_HUMAN, 1'b1, 8'd1);
        step(OP_PRE, 2'd3, 4'd0, 4'd0, 1'b0);
        core("h_limit", S_HUMAN, 1'b1, 8'd1);
        chk("h_limit_we", int'(o_we), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
